seu_npu_evt_sync: RTL and testbench
===================================

Name: seu_npu_evt_sync

Overview:
Parametrised N-channel event synchroniser for the clk_cal domain. It is the successor to the fixed-function start/done pulse synchroniser.
- Each channel takes an asynchronous control line (e.g. pe_cal_start, pe_tx_ofm_done from the transfer side).
- Per channel: SYNC_STG-deep synchroniser, optional glitch filter, per-channel edge-mode selection, sticky pending flag with clear handshake, overflow detection.
- Feeds the PE control FSMs.

Parameters:
- CH_NUM, 8, number of channels (1..32).
- SYNC_STG, 2, synchroniser flop stages (>=2).
- FLT_LEN, 0, glitch filter: synchronised input must hold FLT_LEN+1 consecutive cycles before acceptance; 0 = filter bypassed.
- CNT_W, 4, event counter width (optional feature only).

Ports:
- clk_cal, in, 1, the single clock; all logic on posedge.
- rst, in, 1, synchronous, active-high reset.
- async_in, in, CH_NUM, asynchronous event lines.
- edge_mode, in, 2*CH_NUM, per-channel mode, quasi-static: 00 level, 01 rise, 10 fall, 11 both.
- evt_clr, in, CH_NUM, per-channel clear of evt_pend/evt_ovf (one-cycle strobe or level).
- evt_pulse, out, CH_NUM, one-cycle event strobe (level mode: follows filtered level).
- evt_level, out, CH_NUM, filtered synchronised level.
- evt_pend, out, CH_NUM, sticky pending flag.
- evt_ovf, out, CH_NUM, sticky "event while pending" flag.
- evt_any, out, 1, OR of evt_pend.

Behaviour:
- Reset: rst sampled high at a clk_cal edge clears all sync flops, f, f_d, filter counters, evt_pend, evt_ovf, counters. All outputs read 0 in the cycle after that edge. Reset mid-operation discards in-flight events; no pulse is generated by reset release itself.
- Sync chain: sync[0] <= async_in; sync[i] <= sync[i-1]; s = sync[SYNC_STG-1].
- Filter, per channel, counter width max(1, clog2(FLT_LEN+1)), evaluated at each edge:
  - if s == f: cnt <= 0.
  - else if cnt == FLT_LEN: f <= s, cnt <= 0.
  - else: cnt <= cnt+1.
  - Excursions shorter than FLT_LEN+1 cycles are rejected.
- f_d <= f every cycle. evt_level = f.
- evt_pulse is combinational from registers only:
  - rise: f & ~f_d.
  - fall: ~f & f_d.
  - both: f ^ f_d.
  - level: f.
- Latency: async_in change captured at edge 1 → f updates at edge SYNC_STG+1+FLT_LEN → evt_pulse high for exactly the following cycle. With defaults: pulse in the cycle after edge 3.
- Pending handshake, per edge:
  - evt_pulse & evt_clr → pend <= 1, ovf <= 0 (set wins; event never lost).
  - evt_pulse & pend & ~evt_clr → ovf <= 1.
  - evt_pulse & ~pend → pend <= 1.
  - evt_clr only → pend <= 0, ovf <= 0.
- Level mode: pend re-sets every cycle f = 1, so clear is ineffective while the line is high. ovf is never set in level mode.
- evt_any = |evt_pend, combinational.
- edge_mode change takes effect next cycle. No spurious pulse, since detection uses only f/f_d.
- A line already high at reset release appears as a rising event after SYNC_STG+1+FLT_LEN edges. This is intended: the level is unknown before reset.

Optional Feature:
SEU_NPU_EVT_CNT_EN.
- Defined: adds output evt_cnt (CH_NUM*CNT_W), a per-channel saturating count of evt_pulse strobes (rise/fall/both modes; level mode counts cycles).
  - Holds at 2^CNT_W-1.
  - evt_clr zeroes it; pulse and clr in the same cycle → 1.
  - Reset → 0.
- Undefined: port and counters absent; all other behaviour identical.

Decomposition:
- Package seu_npu_sync_pkg holds:
  - edge-mode encodings EVT_MODE_LVL/RISE/FALL/BOTH (2-bit);
  - a clog2 width function;
  - the SYNC_STG minimum constant (2).
- Natural sub-module: seu_npu_evt_ch, one channel covering sync chain, filter, edge detect, pend/ovf and the optional counter. The top generate-instantiates CH_NUM copies and ORs evt_pend.

Test Plan:
1. Defaults, ch0 rise mode; async_in[0] 0→1 before edge 1 → evt_pulse[0] = 1 for one cycle after edge 3; evt_pend[0] = 1 from edge 4 until evt_clr[0]; evt_any = 1.
2. FLT_LEN=3, rise mode: async_in[2] high for 3 cycles → no pulse, evt_level stays 0; high for 4 cycles → exactly one pulse, 3 cycles later than in test 1.
3. Both mode on ch5: 0→1, then 1→0 ten cycles later → two single-cycle pulses 10 cycles apart; second pulse with pend set and no clr → evt_ovf[5] = 1.
4. Clear collision: evt_clr[1] asserted in the same cycle as evt_pulse[1] with pend = ovf = 1 → next cycle pend = 1, ovf = 0; clr alone next cycle → pend = 0.
5. rst high for one edge while ch3 has pend = 1 and filter count = 2 → all outputs 0 after that edge; input held steady → no pulse after release unless the filtered level differs from 0.
6. SEU_NPU_EVT_CNT_EN, CNT_W=4, 20 rise events on ch7 without clear → evt_cnt[ch7] = 15; evt_clr[7] → 0; pulse and clr together → 1.

Source files
------------

// File: rtl/seu_npu_sync_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seu_npu_sync_pkg
//  Description : Shared constants and helpers for the clk_cal event
//                synchroniser: edge-mode encodings, the minimum synchroniser
//                depth and a constant-evaluable ceil(log2) width function.
//  Revision    : 1.0 - initial release
// ============================================================================
package seu_npu_sync_pkg;

    // Per-channel edge-mode encodings (edge_mode[2c+1:2c])
    localparam logic [1:0] EVT_MODE_LVL  = 2'b00;
    localparam logic [1:0] EVT_MODE_RISE = 2'b01;
    localparam logic [1:0] EVT_MODE_FALL = 2'b10;
    localparam logic [1:0] EVT_MODE_BOTH = 2'b11;

    // Fewer than two flops gives no meaningful metastability protection
    localparam int c_SYNC_STG_MIN = 2;

    // ceil(log2(value)); returns 0 for value <= 1
    function automatic int clog2w(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage : seu_npu_sync_pkg
`default_nettype wire

// File: rtl/seu_npu_evt_ch.sv
`default_nettype none
// ============================================================================
//  Module      : seu_npu_evt_ch
//  Description : One event-synchroniser channel: SYNC_STG-deep synchroniser,
//                optional glitch filter, edge-mode selection, sticky pending
//                and overflow flags with clear handshake.
//                Optional saturating event counter when SEU_NPU_EVT_CNT_EN
//                is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module seu_npu_evt_ch
    import seu_npu_sync_pkg::*;
#(
    parameter int SYNC_STG = 2,
    parameter int FLT_LEN  = 0,
    parameter int CNT_W    = 4
) (
    input  logic             clk_cal,
    input  logic             rst,
    input  logic             async_in,
    input  logic [1:0]       edge_mode,
    input  logic             evt_clr,
    output logic             evt_pulse,
    output logic             evt_level,
    output logic             evt_pend,
`ifdef SEU_NPU_EVT_CNT_EN
    output logic             evt_ovf,
    output logic [CNT_W-1:0] evt_cnt
`else
    output logic             evt_ovf
`endif
);

    // Filter counter must hold 0..FLT_LEN and is never narrower than one bit
    localparam int c_FW = (clog2w(FLT_LEN + 1) < 1) ? 1 : clog2w(FLT_LEN + 1);
    localparam logic [c_FW-1:0] c_FLT_MAX = c_FW'(FLT_LEN);

    // Elaboration-time rejection of unusable configurations
    if (SYNC_STG < c_SYNC_STG_MIN || FLT_LEN < 0 || CNT_W < 1) begin : g_bad_param
        $error("seu_npu_evt_ch: illegal SYNC_STG/FLT_LEN/CNT_W");
    end

    logic [SYNC_STG-1:0] r_sync;
    logic                r_f;
    logic                r_f_d;
    logic [c_FW-1:0]     r_flt_cnt;
    logic                r_pend;
    logic                r_ovf;
    logic                w_s;
    logic                w_pulse;

    assign w_s = r_sync[SYNC_STG-1];

    // Synchroniser shift chain; sync[0] captures the asynchronous line
    always_ff @(posedge clk_cal) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STG-2:0], async_in};
        end
    end

    // Glitch filter: accept a new level only after FLT_LEN+1 agreeing cycles
    always_ff @(posedge clk_cal) begin
        if (rst) begin
            r_f       <= 1'b0;
            r_flt_cnt <= '0;
        end else if (w_s == r_f) begin
            r_flt_cnt <= '0;
        end else if (r_flt_cnt == c_FLT_MAX) begin
            r_f       <= w_s;
            r_flt_cnt <= '0;
        end else begin
            r_flt_cnt <= r_flt_cnt + c_FW'(1);
        end
    end

    // Delayed filtered level for edge detection
    always_ff @(posedge clk_cal) begin
        if (rst) begin
            r_f_d <= 1'b0;
        end else begin
            r_f_d <= r_f;
        end
    end

    // Edge detection from registers only, so a mode change cannot glitch
    always_comb begin
        w_pulse = 1'b0;
        case (edge_mode)
            EVT_MODE_LVL:  w_pulse = r_f;
            EVT_MODE_RISE: w_pulse = r_f & ~r_f_d;
            EVT_MODE_FALL: w_pulse = ~r_f & r_f_d;
            EVT_MODE_BOTH: w_pulse = r_f ^ r_f_d;
            default:       w_pulse = 1'b0;
        endcase
    end

    // Pending/overflow handshake; a new event always beats a clear
    always_ff @(posedge clk_cal) begin
        if (rst) begin
            r_pend <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (w_pulse) begin
            r_pend <= 1'b1;
            if (evt_clr) begin
                r_ovf <= 1'b0;
            end else if (r_pend && (edge_mode != EVT_MODE_LVL)) begin
                r_ovf <= 1'b1;
            end
        end else if (evt_clr) begin
            r_pend <= 1'b0;
            r_ovf  <= 1'b0;
        end
    end

`ifdef SEU_NPU_EVT_CNT_EN
    logic [CNT_W-1:0] r_cnt;

    // Saturating strobe counter; clear together with a strobe restarts at 1
    always_ff @(posedge clk_cal) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (evt_clr) begin
            r_cnt <= w_pulse ? CNT_W'(1) : '0;
        end else if (w_pulse && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign evt_cnt = r_cnt;
`endif

    assign evt_pulse = w_pulse;
    assign evt_level = r_f;
    assign evt_pend  = r_pend;
    assign evt_ovf   = r_ovf;

endmodule : seu_npu_evt_ch
`default_nettype wire

// File: rtl/seu_npu_evt_sync.sv
`default_nettype none
// ============================================================================
//  Module      : seu_npu_evt_sync
//  Description : CH_NUM-channel event synchroniser for the clk_cal domain.
//                Feeds the PE control FSMs with filtered levels, edge strobes
//                and sticky pending/overflow flags.
//                Optional feature macro: SEU_NPU_EVT_CNT_EN adds evt_cnt, a
//                per-channel saturating CNT_W-bit event counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module seu_npu_evt_sync
    import seu_npu_sync_pkg::*;
#(
    parameter int CH_NUM   = 8,
    parameter int SYNC_STG = 2,
    parameter int FLT_LEN  = 0,
    parameter int CNT_W    = 4
) (
    input  logic                    clk_cal,
    input  logic                    rst,
    input  logic [CH_NUM-1:0]       async_in,
    input  logic [2*CH_NUM-1:0]     edge_mode,
    input  logic [CH_NUM-1:0]       evt_clr,
    output logic [CH_NUM-1:0]       evt_pulse,
    output logic [CH_NUM-1:0]       evt_level,
    output logic [CH_NUM-1:0]       evt_pend,
    output logic [CH_NUM-1:0]       evt_ovf,
`ifdef SEU_NPU_EVT_CNT_EN
    output logic                    evt_any,
    output logic [CH_NUM*CNT_W-1:0] evt_cnt
`else
    output logic                    evt_any
`endif
);

    // Elaboration-time channel-count range check
    if (CH_NUM < 1 || CH_NUM > 32) begin : g_bad_ch_num
        $error("seu_npu_evt_sync: CH_NUM must be 1..32");
    end

    // One independent synchroniser per channel
    for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
        seu_npu_evt_ch #(
            .SYNC_STG (SYNC_STG),
            .FLT_LEN  (FLT_LEN),
            .CNT_W    (CNT_W)
        ) u_ch (
            .clk_cal   (clk_cal),
            .rst       (rst),
            .async_in  (async_in[g]),
            .edge_mode (edge_mode[2*g +: 2]),
            .evt_clr   (evt_clr[g]),
            .evt_pulse (evt_pulse[g]),
            .evt_level (evt_level[g]),
            .evt_pend  (evt_pend[g]),
`ifdef SEU_NPU_EVT_CNT_EN
            .evt_ovf   (evt_ovf[g]),
            .evt_cnt   (evt_cnt[g*CNT_W +: CNT_W])
`else
            .evt_ovf   (evt_ovf[g])
`endif
        );
    end

    assign evt_any = |evt_pend;

endmodule : seu_npu_evt_sync
`default_nettype wire

// File: tb/tb_seu_npu_evt_sync.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seu_npu_evt_sync
//  Description : Self-checking bench for seu_npu_evt_sync. Two instances share
//                the stimulus: u_dut with defaults and u_dut_f with FLT_LEN=3.
//                Channel modes: ch0-3,7 rise, ch4,6 level, ch5 both.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seu_npu_evt_sync;

    logic        clk_cal = 1'b0;
    logic        rst;
    logic [7:0]  async_in;
    logic [15:0] edge_mode;
    logic [7:0]  evt_clr;

    logic [7:0]  d_pulse, d_level, d_pend, d_ovf;
    logic        d_any;
    logic [7:0]  f_pulse, f_level, f_pend, f_ovf;
    logic        f_any;
`ifdef SEU_NPU_EVT_CNT_EN
    logic [31:0] d_cnt, f_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_cal = ~clk_cal;

    seu_npu_evt_sync #(.CH_NUM(8), .SYNC_STG(2), .FLT_LEN(0), .CNT_W(4)) u_dut (
        .clk_cal   (clk_cal),
        .rst       (rst),
        .async_in  (async_in),
        .edge_mode (edge_mode),
        .evt_clr   (evt_clr),
        .evt_pulse (d_pulse),
        .evt_level (d_level),
        .evt_pend  (d_pend),
        .evt_ovf   (d_ovf),
`ifdef SEU_NPU_EVT_CNT_EN
        .evt_any   (d_any),
        .evt_cnt   (d_cnt)
`else
        .evt_any   (d_any)
`endif
    );

    seu_npu_evt_sync #(.CH_NUM(8), .SYNC_STG(2), .FLT_LEN(3), .CNT_W(4)) u_dut_f (
        .clk_cal   (clk_cal),
        .rst       (rst),
        .async_in  (async_in),
        .edge_mode (edge_mode),
        .evt_clr   (evt_clr),
        .evt_pulse (f_pulse),
        .evt_level (f_level),
        .evt_pend  (f_pend),
        .evt_ovf   (f_ovf),
`ifdef SEU_NPU_EVT_CNT_EN
        .evt_any   (f_any),
        .evt_cnt   (f_cnt)
`else
        .evt_any   (f_any)
`endif
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] clr;
        logic [7:0] pulse;
        logic [7:0] level;
        logic [7:0] pend;
        logic [7:0] ovf;
        logic       any;
    } vec_t;

    vec_t vec [10];

    // Inputs change at negedge; one call spans one active edge and samples
    // outputs at the following negedge.
    task automatic cyc();
        @(posedge clk_cal);
        @(negedge clk_cal);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        async_in = '0;
        evt_clr  = '0;
        cyc();
        rst = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_d"}, {d_pulse, d_level, d_pend, d_ovf}, 32'h0);
        chk({tag, "_d_any"}, 32'(d_any), 32'h0);
        chk({tag, "_f"}, {f_pulse, f_level, f_pend, f_ovf}, 32'h0);
        chk({tag, "_f_any"}, 32'(f_any), 32'h0);
`ifdef SEU_NPU_EVT_CNT_EN
        chk({tag, "_d_cnt"}, d_cnt, 32'h0);
        chk({tag, "_f_cnt"}, f_cnt, 32'h0);
`endif
    endtask

    initial begin
        // Test 1 table for ch0 (rise mode), rows stepped one edge at a time
        //            a      clr    pulse  level  pend   ovf    any
        vec[0] = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};
        vec[1] = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};
        vec[2] = '{8'h01, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 1'b0};
        vec[3] = '{8'h01, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 1'b1};
        vec[4] = '{8'h01, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 1'b1};
        vec[5] = '{8'h01, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 1'b0};
        vec[6] = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 1'b0};
        vec[7] = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 1'b0};
        vec[8] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};
        vec[9] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};

        rst       = 1'b1;
        async_in  = '0;
        evt_clr   = '0;
        edge_mode = 16'h4C55;
        @(negedge clk_cal);
        cyc();
        chk_all_zero("reset");
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            async_in = vec[i].a;
            evt_clr  = vec[i].clr;
            cyc();
            chk($sformatf("t1_pulse_%0d", i), 32'(d_pulse), 32'(vec[i].pulse));
            chk($sformatf("t1_level_%0d", i), 32'(d_level), 32'(vec[i].level));
            chk($sformatf("t1_pend_%0d", i),  32'(d_pend),  32'(vec[i].pend));
            chk($sformatf("t1_ovf_%0d", i),   32'(d_ovf),   32'(vec[i].ovf));
            chk($sformatf("t1_any_%0d", i),   32'(d_any),   32'(vec[i].any));
        end
        evt_clr = '0;

        // Test 3: ch5 both mode, rise then fall ten cycles later
        do_reset();
        async_in[5] = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            if (i == 11) async_in[5] = 1'b0;
            cyc();
            chk($sformatf("t3_pulse_%0d", i), 32'(d_pulse[5]), 32'((i == 3) || (i == 13)));
            if (i == 12) chk("t3_ovf_before", 32'(d_ovf[5]), 32'h0);
        end
        chk("t3_ovf", 32'(d_ovf[5]), 32'h1);
        chk("t3_pend", 32'(d_pend[5]), 32'h1);

        // Test 4: ch1 rise mode, clear colliding with a pulse
        do_reset();
        async_in[1] = 1'b1; repeat (3) cyc();
        chk("t4_pulse1", 32'(d_pulse[1]), 32'h1);
        async_in[1] = 1'b0; repeat (3) cyc();
        async_in[1] = 1'b1; repeat (3) cyc();
        chk("t4_pulse2", 32'(d_pulse[1]), 32'h1);
        async_in[1] = 1'b0; repeat (3) cyc();
        chk("t4_pend_ovf", {d_pend[1], d_ovf[1]}, 32'h3);
        async_in[1] = 1'b1; repeat (3) cyc();
        chk("t4_pulse3", 32'(d_pulse[1]), 32'h1);
        chk("t4_pre_clr", {d_pend[1], d_ovf[1]}, 32'h3);
        evt_clr[1] = 1'b1; cyc();
        chk("t4_collide", {d_pend[1], d_ovf[1]}, 32'h2);
        cyc();
        chk("t4_clr_alone", {d_pend[1], d_ovf[1]}, 32'h0);
        evt_clr[1] = 1'b0;

        // Level mode on ch4: clear ineffective while high, no overflow
        do_reset();
        async_in[4] = 1'b1; repeat (3) cyc();
        chk("lvl_pulse", {d_pulse[4], d_level[4]}, 32'h3);
        cyc();
        chk("lvl_pend", 32'(d_pend[4]), 32'h1);
        cyc();
        chk("lvl_no_ovf", 32'(d_ovf[4]), 32'h0);
        evt_clr[4] = 1'b1; repeat (2) cyc();
        chk("lvl_clr_held", {d_pend[4], d_ovf[4]}, 32'h2);
        async_in[4] = 1'b0; repeat (3) cyc();
        chk("lvl_low", {d_pulse[4], d_level[4]}, 32'h0);
        cyc();
        chk("lvl_cleared", {d_pend[4], d_any}, 32'h0);
        evt_clr[4] = 1'b0;

        // Test 2: FLT_LEN=3 on ch2, 3-cycle glitch rejected, 4-cycle accepted
        do_reset();
        async_in[2] = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            if (i == 4) async_in[2] = 1'b0;
            cyc();
            chk($sformatf("t2_short_%0d", i), {f_pulse[2], f_level[2]}, 32'h0);
        end
        async_in[2] = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            if (i == 5) async_in[2] = 1'b0;
            cyc();
            chk($sformatf("t2_pulse_%0d", i), 32'(f_pulse[2]), 32'(i == 6));
            chk($sformatf("t2_level_%0d", i), 32'(f_level[2]), 32'((i >= 6) && (i <= 9)));
        end

        // Test 5: reset while ch3 pending with filter count mid-way
        do_reset();
        async_in[3] = 1'b1; repeat (6) cyc();
        chk("t5_pulse", 32'(f_pulse[3]), 32'h1);
        cyc();
        async_in[3] = 1'b0; repeat (4) cyc();
        chk("t5_pre_rst", {f_level[3], f_pend[3]}, 32'h3);
        rst = 1'b1; cyc();
        chk_all_zero("t5_rst");
        rst = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            cyc();
            chk($sformatf("t5_post_%0d", i), {f_pulse, f_level, f_pend, d_pulse}, 32'h0);
        end

`ifdef SEU_NPU_EVT_CNT_EN
        // Test 6: ch7 saturating counter
        do_reset();
        for (int e = 1; e <= 20; e++) begin
            async_in[7] = 1'b1; repeat (3) cyc();
            async_in[7] = 1'b0; repeat (3) cyc();
            if (e == 10) chk("t6_cnt10", 32'(d_cnt[31:28]), 32'd10);
        end
        chk("t6_sat", 32'(d_cnt[31:28]), 32'd15);
        evt_clr[7] = 1'b1; cyc();
        chk("t6_clr", 32'(d_cnt[31:28]), 32'd0);
        evt_clr[7] = 1'b0;
        async_in[7] = 1'b1; repeat (3) cyc();
        chk("t6_pulse", 32'(d_pulse[7]), 32'h1);
        evt_clr[7] = 1'b1; cyc();
        chk("t6_clr_pulse", 32'(d_cnt[31:28]), 32'd1);
        evt_clr[7] = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_seu_npu_evt_sync
`default_nettype wire
